// File: rtl/pck_ejector.sv
// pck_ejector: NoC local-port receiver. Reassembles flits into packets
// independently per virtual channel, returns one credit per accepted flit,
// and presents a one-cycle record (data, size, source, class, weight, VC,
// header-to-tail delay) for every completed packet.
module pck_ejector #(
  parameter int V           = 4,
  parameter int Fpay        = 32,
  parameter int EAw         = 4,
  parameter int DAw         = 4,
  parameter int DSTPw       = 4,
  parameter int Cw          = 1,
  parameter int WEIGHTw     = 4,
  parameter int PCK_INJ_Dw  = 64,
  parameter int MAX_PCK_SIZ = 16,
  localparam int PCK_SIZw   = $clog2(MAX_PCK_SIZ + 1),
  localparam int Fw         = 2 + V + Fpay
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_in_wr,
  input  logic [Fw-1:0]         flit_in,
  output logic [V-1:0]          credit_out,
  output logic                  pck_wr,
  output logic [PCK_INJ_Dw-1:0] pck_data,
  output logic [PCK_SIZw-1:0]   pck_size,
  output logic [EAw-1:0]        pck_src_e_addr,
  output logic [Cw-1:0]         pck_class_num,
  output logic [WEIGHTw-1:0]    pck_init_weight,
  output logic [V-1:0]          pck_vc,
  output logic [15:0]           pck_h2t_delay,
  output logic                  err_hdr_busy,
  output logic                  err_body_idle,
  output logic                  err_vc
);

  localparam int Vw       = (V > 1) ? $clog2(V) : 1;
  localparam int HDRw     = EAw + DAw + DSTPw + Cw + WEIGHTw;
  localparam int HDR_DATw = Fpay - HDRw;
  localparam int CLS_LSB  = EAw + DAw + DSTPw;
  localparam int WT_LSB   = CLS_LSB + Cw;

  typedef enum logic {
    ST_IDLE,
    ST_BODY
  } state_t;

  // Per-VC reassembly context
  state_t                r_state [V];
  logic [PCK_INJ_Dw-1:0] r_data  [V];
  logic [PCK_SIZw-1:0]   r_size  [V];
  logic [EAw-1:0]        r_src   [V];
  logic [Cw-1:0]         r_class [V];
  logic [WEIGHTw-1:0]    r_weight[V];
  logic [15:0]           r_delay [V];

  // Registered outputs
  logic [V-1:0]          r_credit;
  logic                  r_pck_wr;
  logic [PCK_INJ_Dw-1:0] r_pck_data;
  logic [PCK_SIZw-1:0]   r_pck_size;
  logic [EAw-1:0]        r_pck_src;
  logic [Cw-1:0]         r_pck_class;
  logic [WEIGHTw-1:0]    r_pck_weight;
  logic [V-1:0]          r_pck_vc;
  logic [15:0]           r_pck_delay;
  logic                  r_err_hdr_busy;
  logic                  r_err_body_idle;
  logic                  r_err_vc;

  // Flit decode
  logic                  w_hdr;
  logic                  w_tail;
  logic [V-1:0]          w_vc;
  logic [Fpay-1:0]       w_pay;
  logic                  w_vc_ok;
  logic [Vw-1:0]         w_idx;
  state_t                w_cur;
  logic [EAw-1:0]        w_hdr_src;
  logic [Cw-1:0]         w_hdr_class;
  logic [WEIGHTw-1:0]    w_hdr_weight;
  logic [PCK_INJ_Dw-1:0] w_hdr_data;
  int unsigned           w_off;
  logic [PCK_INJ_Dw-1:0] w_ins;
  logic [PCK_INJ_Dw-1:0] w_mask;
  logic [PCK_INJ_Dw-1:0] w_merged;
  logic [PCK_SIZw-1:0]   w_size_nxt;
  logic [15:0]           w_dly_nxt;
  logic                  w_unused_route;

  assign w_hdr  = flit_in[Fw-1];
  assign w_tail = flit_in[Fw-2];
  assign w_vc   = flit_in[Fpay +: V];
  assign w_pay  = flit_in[Fpay-1:0];

  // Destination fields are consumed by the router; nothing to do with them here
  assign w_unused_route = ^w_pay[CLS_LSB-1:EAw];

  assign w_hdr_src    = w_pay[EAw-1:0];
  assign w_hdr_class  = w_pay[CLS_LSB +: Cw];
  assign w_hdr_weight = w_pay[WT_LSB +: WEIGHTw];
  assign w_hdr_data   = PCK_INJ_Dw'(w_pay[Fpay-1:HDRw]);

  // One-hot check and VC index extraction
  always_comb begin
    w_vc_ok = (w_vc != '0) && ((w_vc & (w_vc - V'(1))) == '0);
    w_idx   = '0;
    for (int unsigned v = 0; v < V; v++) begin
      if (w_vc[v]) w_idx = Vw'(v);
    end
  end

  assign w_cur = r_state[w_idx];

  // Placement of a body/tail flit: the k-th body flit (k = current size)
  // lands at HDR_DATw + (k-1)*Fpay; shifts past the top fall off naturally.
  always_comb begin
    w_off      = HDR_DATw + (32'(r_size[w_idx]) - 32'd1) * Fpay;
    w_ins      = PCK_INJ_Dw'(w_pay) << w_off;
    w_mask     = PCK_INJ_Dw'({Fpay{1'b1}}) << w_off;
    w_merged   = (r_data[w_idx] & ~w_mask) | w_ins;
    w_size_nxt = (r_size[w_idx] == '1) ? r_size[w_idx] : r_size[w_idx] + PCK_SIZw'(1);
    w_dly_nxt  = (r_delay[w_idx] == 16'hFFFF) ? 16'hFFFF : r_delay[w_idx] + 16'd1;
  end

  // Per-VC reassembly FSMs, credit return, packet record and error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned v = 0; v < V; v++) begin
        r_state[v]  <= ST_IDLE;
        r_data[v]   <= '0;
        r_size[v]   <= '0;
        r_src[v]    <= '0;
        r_class[v]  <= '0;
        r_weight[v] <= '0;
        r_delay[v]  <= '0;
      end
      r_credit        <= '0;
      r_pck_wr        <= 1'b0;
      r_pck_data      <= '0;
      r_pck_size      <= '0;
      r_pck_src       <= '0;
      r_pck_class     <= '0;
      r_pck_weight    <= '0;
      r_pck_vc        <= '0;
      r_pck_delay     <= '0;
      r_err_hdr_busy  <= 1'b0;
      r_err_body_idle <= 1'b0;
      r_err_vc        <= 1'b0;
    end else begin
      r_credit        <= '0;
      r_pck_wr        <= 1'b0;
      r_err_hdr_busy  <= 1'b0;
      r_err_body_idle <= 1'b0;
      r_err_vc        <= 1'b0;

      // Delay counters free-run while a VC is mid-packet
      for (int unsigned v = 0; v < V; v++) begin
        if (r_state[v] == ST_BODY && r_delay[v] != 16'hFFFF)
          r_delay[v] <= r_delay[v] + 16'd1;
      end

      if (flit_in_wr) begin
        if (!w_vc_ok) begin
          r_err_vc <= 1'b1;
        end else begin
          r_credit <= w_vc;
          if (w_hdr) begin
            if (w_cur == ST_BODY) r_err_hdr_busy <= 1'b1;
            if (w_tail) begin
              r_state[w_idx] <= ST_IDLE;
              r_pck_wr       <= 1'b1;
              r_pck_data     <= w_hdr_data;
              r_pck_size     <= PCK_SIZw'(1);
              r_pck_src      <= w_hdr_src;
              r_pck_class    <= w_hdr_class;
              r_pck_weight   <= w_hdr_weight;
              r_pck_vc       <= w_vc;
              r_pck_delay    <= '0;
            end else begin
              r_state[w_idx]  <= ST_BODY;
              r_data[w_idx]   <= w_hdr_data;
              r_size[w_idx]   <= PCK_SIZw'(1);
              r_src[w_idx]    <= w_hdr_src;
              r_class[w_idx]  <= w_hdr_class;
              r_weight[w_idx] <= w_hdr_weight;
              r_delay[w_idx]  <= '0;
            end
          end else if (w_cur == ST_IDLE) begin
            r_err_body_idle <= 1'b1;
          end else begin
            r_data[w_idx] <= w_merged;
            r_size[w_idx] <= w_size_nxt;
            if (w_tail) begin
              r_state[w_idx] <= ST_IDLE;
              r_pck_wr       <= 1'b1;
              r_pck_data     <= w_merged;
              r_pck_size     <= w_size_nxt;
              r_pck_src      <= r_src[w_idx];
              r_pck_class    <= r_class[w_idx];
              r_pck_weight   <= r_weight[w_idx];
              r_pck_vc       <= w_vc;
              r_pck_delay    <= w_dly_nxt;
            end
          end
        end
      end
    end
  end

  assign credit_out      = r_credit;
  assign pck_wr          = r_pck_wr;
  assign pck_data        = r_pck_data;
  assign pck_size        = r_pck_size;
  assign pck_src_e_addr  = r_pck_src;
  assign pck_class_num   = r_pck_class;
  assign pck_init_weight = r_pck_weight;
  assign pck_vc          = r_pck_vc;
  assign pck_h2t_delay   = r_pck_delay;
  assign err_hdr_busy    = r_err_hdr_busy;
  assign err_body_idle   = r_err_body_idle;
  assign err_vc          = r_err_vc;

endmodule

// File: tb/tb_pck_ejector.sv
// Testbench for pck_ejector: directed flit sequences, a packet-level
// reference model compared every cycle, and hand-computed literal checks.
module tb_pck_ejector;

  logic        clk;
  logic        reset;
  logic        flit_in_wr;
  logic [37:0] flit_in;
  logic [3:0]  credit_out;
  logic        pck_wr;
  logic [63:0] pck_data;
  logic [4:0]  pck_size;
  logic [3:0]  pck_src_e_addr;
  logic [0:0]  pck_class_num;
  logic [3:0]  pck_init_weight;
  logic [3:0]  pck_vc;
  logic [15:0] pck_h2t_delay;
  logic        err_hdr_busy;
  logic        err_body_idle;
  logic        err_vc;

  pck_ejector #(
    .V(4), .Fpay(32), .EAw(4), .DAw(4), .DSTPw(4), .Cw(1),
    .WEIGHTw(4), .PCK_INJ_Dw(64), .MAX_PCK_SIZ(16)
  ) dut (
    .clk(clk), .reset(reset), .flit_in_wr(flit_in_wr), .flit_in(flit_in),
    .credit_out(credit_out), .pck_wr(pck_wr), .pck_data(pck_data),
    .pck_size(pck_size), .pck_src_e_addr(pck_src_e_addr),
    .pck_class_num(pck_class_num), .pck_init_weight(pck_init_weight),
    .pck_vc(pck_vc), .pck_h2t_delay(pck_h2t_delay),
    .err_hdr_busy(err_hdr_busy), .err_body_idle(err_body_idle), .err_vc(err_vc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: raw flit lists per VC plus expected outputs
  logic [31:0] m_fl [4][40];
  int          m_n    [4];
  bit          m_busy [4];
  longint      m_hcyc [4];
  longint      cyc = 0;

  logic [3:0]  m_credit = '0;
  logic        m_wr = 1'b0;
  logic [63:0] m_data = '0;
  logic [4:0]  m_size = '0;
  logic [3:0]  m_src = '0;
  logic [0:0]  m_class = '0;
  logic [3:0]  m_weight = '0;
  logic [3:0]  m_vc = '0;
  logic [15:0] m_delay = '0;
  logic        m_ehb = 1'b0;
  logic        m_ebi = 1'b0;
  logic        m_evc = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Build the expected record from the stored flits of VC i
  task automatic emit(input int i);
    logic [127:0] acc;
    longint       d;
    int           lim;
    acc = 128'(m_fl[i][0][31:17]);
    lim = (m_n[i] > 40) ? 40 : m_n[i];
    for (int k = 1; k < lim; k++) begin
      int off;
      off = 15 + (k - 1) * 32;
      if (off < 64) acc = acc | (128'(m_fl[i][k]) << off);
    end
    d        = cyc - m_hcyc[i];
    m_wr     = 1'b1;
    m_data   = acc[63:0];
    m_size   = (m_n[i] > 31) ? 5'd31 : 5'(m_n[i]);
    m_delay  = (d > 65535) ? 16'hFFFF : 16'(d);
    m_src    = m_fl[i][0][3:0];
    m_class  = m_fl[i][0][12:12];
    m_weight = m_fl[i][0][16:13];
    m_vc     = 4'b0001 << i;
  endtask

  task automatic model_step();
    logic [3:0]  vc;
    logic [31:0] p;
    logic        h, t;
    int          i;
    cyc++;
    m_credit = '0; m_wr = 1'b0; m_ehb = 1'b0; m_ebi = 1'b0; m_evc = 1'b0;
    if (!reset) begin
      for (int v = 0; v < 4; v++) m_busy[v] = 1'b0;
      m_data = '0; m_size = '0; m_src = '0; m_class = '0;
      m_weight = '0; m_vc = '0; m_delay = '0;
    end else if (flit_in_wr) begin
      h  = flit_in[37];
      t  = flit_in[36];
      vc = flit_in[35:32];
      p  = flit_in[31:0];
      if ($countones(vc) != 1) begin
        m_evc = 1'b1;
      end else begin
        i = 0;
        for (int v = 0; v < 4; v++) if (vc[v]) i = v;
        m_credit = vc;
        if (h) begin
          if (m_busy[i]) m_ehb = 1'b1;
          m_n[i] = 1; m_fl[i][0] = p; m_hcyc[i] = cyc;
          if (t) begin emit(i); m_busy[i] = 1'b0; end
          else m_busy[i] = 1'b1;
        end else if (!m_busy[i]) begin
          m_ebi = 1'b1;
        end else begin
          if (m_n[i] < 40) m_fl[i][m_n[i]] = p;
          m_n[i]++;
          if (t) begin emit(i); m_busy[i] = 1'b0; end
        end
      end
    end
  endtask

  task automatic compare();
    chk("credit_out", 64'(credit_out), 64'(m_credit));
    chk("pck_wr", 64'(pck_wr), 64'(m_wr));
    chk("pck_data", pck_data, m_data);
    chk("pck_size", 64'(pck_size), 64'(m_size));
    chk("pck_src", 64'(pck_src_e_addr), 64'(m_src));
    chk("pck_class", 64'(pck_class_num), 64'(m_class));
    chk("pck_weight", 64'(pck_init_weight), 64'(m_weight));
    chk("pck_vc", 64'(pck_vc), 64'(m_vc));
    chk("pck_delay", 64'(pck_h2t_delay), 64'(m_delay));
    chk("err_hdr_busy", 64'(err_hdr_busy), 64'(m_ehb));
    chk("err_body_idle", 64'(err_body_idle), 64'(m_ebi));
    chk("err_vc", 64'(err_vc), 64'(m_evc));
  endtask

  // One clock: model follows the edge, outputs compared 2ns later
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
    compare();
  endtask

  task automatic send(input logic h, input logic t, input logic [3:0] vc, input logic [31:0] p);
    flit_in_wr = 1'b1;
    flit_in    = {h, t, vc, p};
    tick();
    flit_in_wr = 1'b0;
    flit_in    = '0;
  endtask

  function automatic logic [31:0] hdr(input logic [3:0] src, input logic [0:0] cls,
                                      input logic [3:0] wt, input logic [14:0] dat);
    return {dat, wt, cls, 4'h0, 4'h0, src};
  endfunction

  initial begin
    reset = 1'b0; flit_in_wr = 1'b0; flit_in = '0;
    for (int v = 0; v < 4; v++) begin m_n[v] = 0; m_busy[v] = 1'b0; m_hcyc[v] = 0; end
    repeat (3) tick();
    chk("lit_reset_wr", 64'(pck_wr), 64'd0);
    chk("lit_reset_credit", 64'(credit_out), 64'd0);
    chk("lit_reset_data", pck_data, 64'd0);
    reset = 1'b1;
    tick();

    // Single-flit packet
    send(1'b1, 1'b1, 4'b0001, hdr(4'd3, 1'b1, 4'd5, 15'h1234));
    chk("lit_t1_credit", 64'(credit_out), 64'h1);
    chk("lit_t1_wr", 64'(pck_wr), 64'd1);
    chk("lit_t1_size", 64'(pck_size), 64'd1);
    chk("lit_t1_delay", 64'(pck_h2t_delay), 64'd0);
    chk("lit_t1_data", pck_data, 64'h1234);
    chk("lit_t1_vc", 64'(pck_vc), 64'h1);
    chk("lit_t1_src", 64'(pck_src_e_addr), 64'd3);
    chk("lit_t1_class", 64'(pck_class_num), 64'd1);
    chk("lit_t1_weight", 64'(pck_init_weight), 64'd5);
    tick();
    chk("lit_t1_hold_data", pck_data, 64'h1234);

    // 3-flit packet back to back on VC1
    send(1'b1, 1'b0, 4'b0010, hdr(4'd7, 1'b0, 4'd2, 15'h7FFF));
    chk("lit_t2_credit0", 64'(credit_out), 64'h2);
    send(1'b0, 1'b0, 4'b0010, 32'hAAAAAAAA);
    chk("lit_t2_credit1", 64'(credit_out), 64'h2);
    send(1'b0, 1'b1, 4'b0010, 32'h55555555);
    chk("lit_t2_credit2", 64'(credit_out), 64'h2);
    chk("lit_t2_wr", 64'(pck_wr), 64'd1);
    chk("lit_t2_data", pck_data, 64'hAAAA_D555_5555_7FFF);
    chk("lit_t2_size", 64'(pck_size), 64'd3);
    chk("lit_t2_delay", 64'(pck_h2t_delay), 64'd2);
    tick();

    // Interleaved VC0 / VC2
    send(1'b1, 1'b0, 4'b0001, hdr(4'd1, 1'b0, 4'd1, 15'h0011));
    send(1'b1, 1'b0, 4'b0100, hdr(4'd2, 1'b1, 4'd9, 15'h0022));
    send(1'b0, 1'b1, 4'b0001, 32'h0000_0001);
    chk("lit_t3_vc0_wr", 64'(pck_wr), 64'd1);
    chk("lit_t3_vc0_vc", 64'(pck_vc), 64'h1);
    chk("lit_t3_vc0_size", 64'(pck_size), 64'd2);
    send(1'b0, 1'b0, 4'b0100, 32'h1234_5678);
    send(1'b0, 1'b1, 4'b0100, 32'h9ABC_DEF0);
    chk("lit_t3_vc2_vc", 64'(pck_vc), 64'h4);
    chk("lit_t3_vc2_size", 64'(pck_size), 64'd3);
    chk("lit_t3_vc2_delay", 64'(pck_h2t_delay), 64'd3);
    tick();

    // Errors: body on idle VC3, then multi-hot vc
    send(1'b0, 1'b0, 4'b1000, 32'hDEAD_BEEF);
    chk("lit_t4_ebi", 64'(err_body_idle), 64'd1);
    chk("lit_t4_credit", 64'(credit_out), 64'h8);
    chk("lit_t4_wr", 64'(pck_wr), 64'd0);
    send(1'b1, 1'b1, 4'b0011, 32'h0);
    chk("lit_t4_evc", 64'(err_vc), 64'd1);
    chk("lit_t4_nocredit", 64'(credit_out), 64'd0);
    send(1'b1, 1'b1, 4'b0000, 32'h0);
    chk("lit_t4_evc_zero", 64'(err_vc), 64'd1);
    tick();

    // Delay saturation on VC1
    send(1'b1, 1'b0, 4'b0010, hdr(4'd4, 1'b0, 4'd3, 15'h0042));
    repeat (70000) tick();
    send(1'b0, 1'b1, 4'b0010, 32'hCAFE_F00D);
    chk("lit_t5_delay", 64'(pck_h2t_delay), 64'hFFFF);
    chk("lit_t5_size", 64'(pck_size), 64'd2);
    tick();

    // Header on busy VC0, then reset mid-packet on VC2
    send(1'b1, 1'b0, 4'b0001, hdr(4'd5, 1'b0, 4'd1, 15'h0001));
    send(1'b1, 1'b0, 4'b0001, hdr(4'd6, 1'b1, 4'd2, 15'h0002));
    chk("lit_t6_ehb", 64'(err_hdr_busy), 64'd1);
    chk("lit_t6_credit", 64'(credit_out), 64'h1);
    send(1'b0, 1'b1, 4'b0001, 32'h0000_00FF);
    chk("lit_t6_size", 64'(pck_size), 64'd2);
    chk("lit_t6_src", 64'(pck_src_e_addr), 64'd6);
    send(1'b1, 1'b0, 4'b0100, hdr(4'd7, 1'b0, 4'd7, 15'h0077));
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("lit_t6_rst_data", pck_data, 64'd0);
    send(1'b0, 1'b1, 4'b0100, 32'h0000_0123);
    chk("lit_t6_ebi", 64'(err_body_idle), 64'd1);
    chk("lit_t6_nowr", 64'(pck_wr), 64'd0);
    chk("lit_t6_credit2", 64'(credit_out), 64'h4);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pck_ejector.md
# pck_ejector

Endpoint-side receiver for the NoC local port: it accepts flits from the router's local output channel, one flit per cycle. It reassembles them into packets independently per virtual channel and returns one credit per accepted flit. For each completed packet it presents a one-cycle packet-injector-format record. It is the receiving end matching the packet injector: the injector packetizes, this block de-packetizes and reports traffic statistics (size, head-to-tail delay).

## Interface
Parameters:
- V, 4: number of virtual channels; Vw = log2(V)
- Fpay, 32: flit payload width
- EAw, 4: source endpoint address width
- DAw, 4: destination address width
- DSTPw, 4: destination-port field width
- Cw, 1: message class width
- WEIGHTw, 4: WRRA weight width
- PCK_INJ_Dw, 64: reassembled data width
- MAX_PCK_SIZ, 16: maximum flits per packet; PCK_SIZw = log2(MAX_PCK_SIZ+1) = 5
- Derived: HDRw = EAw+DAw+DSTPw+Cw+WEIGHTw = 17; HDR_DATw = Fpay-HDRw = 15; Fw = 2+V+Fpay = 38

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- flit_in_wr  in  1  flit valid
- flit_in  in  Fw  {hdr_flag, tail_flag, vc[V-1:0] one-hot, payload[Fpay-1:0]}
- credit_out  out  V  one-hot credit return
- pck_wr  out  1  one-cycle pulse, packet record valid
- pck_data  out  PCK_INJ_Dw  reassembled data
- pck_size  out  PCK_SIZw  flit count
- pck_src_e_addr  out  EAw  source endpoint
- pck_class_num  out  Cw  message class
- pck_init_weight  out  WEIGHTw  header weight
- pck_vc  out  V  VC the packet arrived on
- pck_h2t_delay  out  16  cycles from header to tail
- err_hdr_busy  out  1  pulse: header received on a busy VC
- err_body_idle  out  1  pulse: body/tail received on an idle VC
- err_vc  out  1  pulse: vc field not one-hot

## Operation
- Header payload layout, LSB first: src_e_addr, dest_e_addr, destport, class, weight, then data payload[Fpay-1:HDRw].
- Each VC has a 2-state FSM: IDLE and BODY, with per-VC registers data, size, src, class, weight, and a 16-bit delay counter.
- Flit accepted with hdr=1, tail=1 in IDLE: single-flit packet.
  - Emit immediately with size=1, delay=0, data = zero-extended header data.
  - State stays IDLE.
- hdr=1, tail=0 in IDLE:
  - Capture the header fields.
  - data[HDR_DATw-1:0] = header data; remaining bits 0.
  - size = 1, delay = 0; go to BODY.
- Body flit (hdr=0, tail=0) in BODY:
  - The k-th body flit (k ≥ 1) is written to bits starting at offset HDR_DATw+(k-1)*Fpay.
  - Bits at or beyond PCK_INJ_Dw are discarded.
  - size increments, saturating at 2^PCK_SIZw-1.
- Tail flit (hdr=0, tail=1) in BODY: place data as for a body flit, increment size, emit the packet, go to IDLE.
- In BODY, the delay counter increments every cycle, saturating at 0xFFFF.
- Header arriving on a VC in BODY:
  - Pulse err_hdr_busy.
  - Discard the partial packet; the new header restarts reassembly (single-flit header: emit it, go IDLE).
- Body or tail flit arriving on a VC in IDLE: drop it, pulse err_body_idle.
- vc field zero or multi-hot: drop the flit, no credit, pulse err_vc, no state change.
- Every flit with one-hot vc returns a credit on that VC, including flits dropped by err_hdr_busy or err_body_idle.
- Only one flit arrives per cycle, so at most one packet completes per cycle. There is no output backpressure; the consumer must sample on pck_wr.
- Reset:
  - All VCs go to IDLE and every output is 0.
  - Partial packets are discarded.
  - Credits for flits accepted in the cycle before reset are not returned.

## Timing
- credit_out is registered: asserted in cycle N+1 for a flit accepted in cycle N, one cycle wide.
- The packet record is registered: pck_wr and all pck_* fields are valid in cycle N+1 for a tail or single-flit packet accepted in cycle N.
- pck_* fields hold their values until the next pck_wr.
- err_* pulses are registered and appear in cycle N+1.
- pck_h2t_delay = tail cycle minus header cycle.
  - A header at cycle N with tail at N+1 gives 1.
- A packet on VC a may complete while VC b is mid-packet. Interleaving flits of different VCs cycle by cycle is legal.

## Test plan
- Single-flit header, vc=0001, src=3, class=1, weight=5, data=0x1234 → next cycle: credit_out=0001; pck_wr=1, size=1, delay=0, data=0x1234, pck_vc=0001.
- 3-flit packet on vc=0010: header data 0x7FFF, body 0xAAAAAAAA, tail 0x55555555, back-to-back → pck_data = {0x55555555[16:0], 0xAAAAAAAA, 0x7FFF}, truncated to 64 bits. Also size=3, delay=2, three credits on VC1.
- Interleave: VC0 header, VC2 header, VC0 tail, VC2 body, VC2 tail → two records, VC0 then VC2, sizes 2 and 3, no errors.
- Body flit on idle VC3 → err_body_idle=1, credit_out=1000, no pck_wr. Then vc=0011 → err_vc=1, no credit.
- Header on VC1, hold VC1 in BODY for 70000 cycles, send tail → delay=0xFFFF, size=2.
- Header on VC0 then a second header on VC0 → err_hdr_busy=1. Assert reset mid-packet on VC2, then send a tail on VC2 → err_body_idle=1, no pck_wr.
